// File: rtl/sdram_s1_responder.sv
// On-chip RAM target speaking the SDRAM controller s1 slave protocol, with
// programmable command stall, fixed read latency and a cap on outstanding reads.
module sdram_s1_responder #(
  parameter int MEM_AW       = 12,
  parameter int READ_LATENCY = 3,
  parameter int WAIT_CYCLES  = 1,
  parameter int MAX_PENDING  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [22:0] new_sdram_controller_0_s1_address,
  input  logic [3:0]  new_sdram_controller_0_s1_byteenable_n,
  input  logic        new_sdram_controller_0_s1_chipselect,
  input  logic [31:0] new_sdram_controller_0_s1_writedata,
  input  logic        new_sdram_controller_0_s1_read_n,
  input  logic        new_sdram_controller_0_s1_write_n,
  output logic [31:0] new_sdram_controller_0_s1_readdata,
  output logic        new_sdram_controller_0_s1_readdatavalid,
  output logic        new_sdram_controller_0_s1_waitrequest,
  output logic        o_proto_err,
  output logic        o_range_err
);
  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam int NS = READ_LATENCY - 1;

  logic [31:0]       mem [0:(1 << MEM_AW) - 1];
  logic [MEM_AW-1:0] waddr;
  logic              cmd, is_write, is_read, wait_c, accept, rd_acc, wr_acc, in_range;
  logic [2:0]        scnt_q, scnt_d;
  logic [PW-1:0]     pending_q, pending_d;
  logic              s0_vld_q, s0_vld_d, s0_oor_q, s0_oor_d;
  logic [31:0]       ram_q, s0_data;
  logic [NS-1:0]     vld_q, vld_d;
  logic [31:0]       dat_q [NS];
  logic [31:0]       dat_d [NS];
  logic              proto_q, proto_d, range_q, range_d;

  always_comb begin
    waddr    = new_sdram_controller_0_s1_address[MEM_AW-1:0];
    in_range = (new_sdram_controller_0_s1_address[22:MEM_AW] == '0);
    is_write = new_sdram_controller_0_s1_chipselect & ~new_sdram_controller_0_s1_write_n;
    // A simultaneous read/write strobe is handled as a write only.
    is_read  = new_sdram_controller_0_s1_chipselect & ~new_sdram_controller_0_s1_read_n
               & new_sdram_controller_0_s1_write_n;
    cmd      = is_write | is_read;
    wait_c   = cmd & ((scnt_q < 3'(WAIT_CYCLES)) |
                      (is_read & (pending_q == PW'(MAX_PENDING))));
    accept   = cmd & ~wait_c;
    wr_acc   = accept & is_write;
    rd_acc   = accept & is_read;

    scnt_d = scnt_q;
    if (!cmd || accept)
      scnt_d = '0;
    else if (scnt_q < 3'(WAIT_CYCLES))
      scnt_d = scnt_q + 3'd1;

    pending_d = pending_q + PW'(rd_acc) - PW'(vld_q[NS-1]);

    s0_vld_d = rd_acc;
    s0_oor_d = rd_acc ? ~in_range : s0_oor_q;
    s0_data  = s0_oor_q ? 32'h0 : ram_q;

    // Data registers only load on a valid beat so the output holds between returns.
    vld_d[0] = s0_vld_q;
    dat_d[0] = s0_vld_q ? s0_data : dat_q[0];
    for (int i = 1; i < NS; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
    end

    proto_d = proto_q | (accept & ~new_sdram_controller_0_s1_read_n
                                & ~new_sdram_controller_0_s1_write_n);
    range_d = range_q | (accept & ~in_range);
  end

  always_ff @(posedge i_clk) begin
    if (rd_acc)
      ram_q <= mem[waddr];
    for (int k = 0; k < 4; k++)
      if (wr_acc && in_range && !new_sdram_controller_0_s1_byteenable_n[k])
        mem[waddr][8*k +: 8] <= new_sdram_controller_0_s1_writedata[8*k +: 8];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scnt_q    <= '0;
      pending_q <= '0;
      s0_vld_q  <= 1'b0;
      s0_oor_q  <= 1'b0;
      vld_q     <= '0;
      for (int i = 0; i < NS; i++)
        dat_q[i] <= '0;
      proto_q   <= 1'b0;
      range_q   <= 1'b0;
    end else begin
      scnt_q    <= scnt_d;
      pending_q <= pending_d;
      s0_vld_q  <= s0_vld_d;
      s0_oor_q  <= s0_oor_d;
      vld_q     <= vld_d;
      for (int i = 0; i < NS; i++)
        dat_q[i] <= dat_d[i];
      proto_q   <= proto_d;
      range_q   <= range_d;
    end
  end

  assign new_sdram_controller_0_s1_readdata      = dat_q[NS-1];
  assign new_sdram_controller_0_s1_readdatavalid = vld_q[NS-1];
  assign new_sdram_controller_0_s1_waitrequest   = wait_c;
  assign o_proto_err                             = proto_q;
  assign o_range_err                             = range_q;
endmodule
